// File: rtl/appx_div_pkg.sv
// Shared types and constants for the 16/8 sequential restoring divider.
package appx_div_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam int unsigned DIVIDEND_W = 16;
  localparam int unsigned DIVISOR_W  = 8;

  localparam logic [DIVIDEND_W-1:0] Q_DZ = 16'hFFFF;

  // Number of RUN cycles once the low quotient iterations are skipped.
  function automatic int unsigned iter_f(input int unsigned skip_bits);
    return DIVIDEND_W - skip_bits;
  endfunction

endpackage

// File: rtl/appx_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract D.
module appx_div_step
  import appx_div_pkg::*;
(
  input  logic [8:0]           pr_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] d_i,
  output logic [8:0]           pr_o,
  output logic                 qbit_o
);

  logic [8:0] t;
  logic       ge;

  always_comb begin
    t  = {pr_i[7:0], bit_i};
    // A set pr_i[8] would put T at or above 512, which always exceeds D.
    ge = pr_i[8] | (t >= {1'b0, d_i});
    if (ge) begin
      pr_o   = t - {1'b0, d_i};
      qbit_o = 1'b1;
    end else begin
      pr_o   = t;
      qbit_o = 1'b0;
    end
  end

endmodule

// File: rtl/appx_div16by8_seq.sv
// Sequential radix-2 restoring divider, 16-bit by 8-bit, with optional skipped quotient LSBs.
module appx_div16by8_seq
  import appx_div_pkg::*;
#(
  parameter int unsigned SKIP_BITS = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DIVIDEND_W-1:0] n_i,
  input  logic [DIVISOR_W-1:0]  d_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DIVIDEND_W-1:0] q_o,
  output logic [DIVIDEND_W-1:0] r_o,
  output logic                  dz_o
);

  localparam int unsigned ITER     = iter_f(SKIP_BITS);
  localparam logic [4:0]  ITER_CNT = 5'(ITER);

  state_e          state_q;
  logic [8:0]      pr_q;
  logic [15:0]     sh_q;
  logic [14:0]     quo_q;
  logic [7:0]      d_q;
  logic [4:0]      cnt_q;
  logic [15:0]     q_q;
  logic [15:0]     r_q;
  logic            dz_q;

  logic [8:0]      pr_step;
  logic            qbit;
  logic [15:0]     quo_next;
  logic [15:0]     sh_next;
  logic [15:0]     q_fin;
  logic [15:0]     r_fin;

  appx_div_step u_step (
    .pr_i   (pr_q),
    .bit_i  (sh_q[15]),
    .d_i    (d_q),
    .pr_o   (pr_step),
    .qbit_o (qbit)
  );

  // After the last step the unprocessed dividend LSBs sit at the top of the shifter.
  always_comb begin
    quo_next = {quo_q, qbit};
    sh_next  = {sh_q[14:0], 1'b0};
    q_fin    = quo_next << SKIP_BITS;
    r_fin    = ({7'b0, pr_step} << SKIP_BITS) | (sh_next >> (DIVIDEND_W - SKIP_BITS));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pr_q    <= '0;
      sh_q    <= '0;
      quo_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            d_q <= d_i;
            if (d_i == '0) begin
              q_q     <= Q_DZ;
              r_q     <= n_i;
              dz_q    <= 1'b1;
              state_q <= StDone;
            end else begin
              pr_q    <= '0;
              sh_q    <= n_i;
              quo_q   <= '0;
              cnt_q   <= ITER_CNT;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          pr_q  <= pr_step;
          sh_q  <= sh_next;
          quo_q <= quo_next[14:0];
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            q_q     <= q_fin;
            r_q     <= r_fin;
            dz_q    <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            dz_q    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign q_o         = q_q;
  assign r_o         = r_q;
  assign dz_o        = dz_q;

endmodule

// File: tb/tb_appx_div16by8_seq.sv
// Directed and randomised checks of the sequential divider, exact and SKIP_BITS=4 builds.
module tb_appx_div16by8_seq;
  import appx_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv = 1'b0, ordy = 1'b0;
  logic        iv4 = 1'b0, ordy4 = 1'b0;
  logic [15:0] n = '0;
  logic [7:0]  d = '0;
  logic        ir, ov, dz, ir4, ov4, dz4;
  logic [15:0] q, r, q4, r4;

  logic [8:0]  st_pr = '0;
  logic        st_bit = 1'b0;
  logic [7:0]  st_d = 8'd1;
  logic [8:0]  st_pr_o;
  logic        st_q_o;

  int n_cmp  = 0;
  int n_fail = 0;

  appx_div16by8_seq #(.SKIP_BITS(0)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv), .in_ready_o(ir), .n_i(n), .d_i(d),
    .out_valid_o(ov), .out_ready_i(ordy), .q_o(q), .r_o(r), .dz_o(dz)
  );

  appx_div16by8_seq #(.SKIP_BITS(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv4), .in_ready_o(ir4), .n_i(n), .d_i(d),
    .out_valid_o(ov4), .out_ready_i(ordy4), .q_o(q4), .r_o(r4), .dz_o(dz4)
  );

  appx_div_step u_ref_step (
    .pr_i(st_pr), .bit_i(st_bit), .d_i(st_d), .pr_o(st_pr_o), .qbit_o(st_q_o)
  );

  // Issue one operation to the exact divider; caller is 1 time unit after a posedge, in IDLE.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input bit retire,
                        output logic [15:0] qo, output logic [15:0] ro, output logic dzo,
                        output int lat);
    n = a; d = b; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0; n = 16'($urandom); d = 8'($urandom);
    lat = 0;
    while (ov !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    qo = q; ro = r; dzo = dz;
    if (retire) begin
      ordy = 1'b1;
      @(posedge clk); #1;
      ordy = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (q !== 16'd0) begin n_fail++; $display("FAIL reset_q: got %h want 0000", q); end
    n_cmp++; if (r !== 16'd0) begin n_fail++; $display("FAIL reset_r: got %h want 0000", r); end
    n_cmp++; if (dz !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b want 0", dz); end
    n_cmp++; if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_ov: got %b want 0", ov); end
    n_cmp++; if (ir !== 1'b1) begin n_fail++; $display("FAIL reset_ir: got %b want 1", ir); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_step();
    st_pr = 9'd3; st_bit = 1'b1; st_d = 8'd7; #1;
    n_cmp++; if ({st_pr_o, st_q_o} !== {9'd0, 1'b1})
      begin n_fail++; $display("FAIL step_eq: got pr=%0d q=%b want pr=0 q=1", st_pr_o, st_q_o); end
    st_bit = 1'b0; #1;
    n_cmp++; if ({st_pr_o, st_q_o} !== {9'd6, 1'b0})
      begin n_fail++; $display("FAIL step_lt: got pr=%0d q=%b want pr=6 q=0", st_pr_o, st_q_o); end
    st_pr = 9'd254; st_bit = 1'b1; st_d = 8'd255; #1;
    n_cmp++; if ({st_pr_o, st_q_o} !== {9'd254, 1'b1})
      begin n_fail++; $display("FAIL step_max: got pr=%0d q=%b want pr=254 q=1", st_pr_o, st_q_o); end
  endtask

  task automatic test_exact();
    logic [15:0] qo, ro;
    logic        dzo;
    int          lat;
    run_op(16'd1000, 8'd7, 1'b1, qo, ro, dzo, lat);
    n_cmp++; if (qo !== 16'd142) begin n_fail++; $display("FAIL q_1000_7: got %0d want 142", qo); end
    n_cmp++; if (ro !== 16'd6) begin n_fail++; $display("FAIL r_1000_7: got %0d want 6", ro); end
    n_cmp++; if (dzo !== 1'b0) begin n_fail++; $display("FAIL dz_1000_7: got %b want 0", dzo); end
    n_cmp++; if (lat != 16) begin n_fail++; $display("FAIL lat_1000_7: got %0d want 16", lat); end
    n_cmp++; if (ov !== 1'b0) begin n_fail++; $display("FAIL ov_after_ack: got %b want 0", ov); end
    run_op(16'hFFFF, 8'd255, 1'b1, qo, ro, dzo, lat);
    n_cmp++; if (qo !== 16'd257) begin n_fail++; $display("FAIL q_ffff_255: got %0d want 257", qo); end
    n_cmp++; if (ro !== 16'd0) begin n_fail++; $display("FAIL r_ffff_255: got %0d want 0", ro); end
    run_op(16'hFFFF, 8'd1, 1'b1, qo, ro, dzo, lat);
    n_cmp++; if (qo !== 16'hFFFF) begin n_fail++; $display("FAIL q_ffff_1: got %h want ffff", qo); end
    n_cmp++; if (ro !== 16'd0) begin n_fail++; $display("FAIL r_ffff_1: got %0d want 0", ro); end
    run_op(16'd5, 8'd200, 1'b1, qo, ro, dzo, lat);
    n_cmp++; if (qo !== 16'd0) begin n_fail++; $display("FAIL q_5_200: got %0d want 0", qo); end
    n_cmp++; if (ro !== 16'd5) begin n_fail++; $display("FAIL r_5_200: got %0d want 5", ro); end
  endtask

  task automatic test_div_zero();
    logic [15:0] qo, ro;
    logic        dzo;
    int          lat;
    run_op(16'd1234, 8'd0, 1'b0, qo, ro, dzo, lat);
    n_cmp++; if (lat != 0) begin n_fail++; $display("FAIL lat_dz: got %0d extra edges want 0", lat); end
    n_cmp++; if (qo !== 16'hFFFF) begin n_fail++; $display("FAIL q_dz: got %h want ffff", qo); end
    n_cmp++; if (ro !== 16'h04D2) begin n_fail++; $display("FAIL r_dz: got %h want 04d2", ro); end
    n_cmp++; if (dzo !== 1'b1) begin n_fail++; $display("FAIL dz_set: got %b want 1", dzo); end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    n_cmp++; if (dz !== 1'b0) begin n_fail++; $display("FAIL dz_clear: got %b want 0", dz); end
    n_cmp++; if (ir !== 1'b1) begin n_fail++; $display("FAIL ir_after_dz: got %b want 1", ir); end
  endtask

  task automatic test_skip4();
    int lat;
    n = 16'd1000; d = 8'd7; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    lat = 0;
    while (ov4 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (lat != 12) begin n_fail++; $display("FAIL lat_skip4: got %0d want 12", lat); end
    n_cmp++; if (q4 !== 16'd128) begin n_fail++; $display("FAIL q_skip4: got %0d want 128", q4); end
    n_cmp++; if (r4 !== 16'd104) begin n_fail++; $display("FAIL r_skip4: got %0d want 104", r4); end
    n_cmp++; if (dz4 !== 1'b0) begin n_fail++; $display("FAIL dz_skip4: got %b want 0", dz4); end
    ordy4 = 1'b1;
    @(posedge clk); #1;
    ordy4 = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] qo, ro;
    logic        dzo;
    int          lat;
    run_op(16'd1000, 8'd7, 1'b0, qo, ro, dzo, lat);
    for (int i = 0; i < 5; i++) begin
      iv = 1'b1; n = 16'(i * 4321 + 17); d = 8'(i * 37 + 3);
      @(posedge clk); #1;
      n_cmp++;
      if (q !== 16'd142 || r !== 16'd6 || ir !== 1'b0 || ov !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got q=%0d r=%0d ir=%b ov=%b want q=142 r=6 ir=0 ov=1",
                 i, q, r, ir, ov);
      end
    end
    iv = 1'b0; ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    n_cmp++; if (ir !== 1'b1 || ov !== 1'b0)
      begin n_fail++; $display("FAIL bp_release: got ir=%b ov=%b want ir=1 ov=0", ir, ov); end
    run_op(16'hFFFF, 8'd1, 1'b0, qo, ro, dzo, lat);
    n_cmp++; if (qo !== 16'hFFFF || lat != 16)
      begin n_fail++; $display("FAIL bp_next_op: got q=%h lat=%0d want q=ffff lat=16", qo, lat); end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] qo, ro;
    logic        dzo;
    int          lat;
    // The previous result (ffff) is still held in DONE; acknowledge it first.
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    n = 16'd1000; d = 8'd7; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (q !== 16'd0 || r !== 16'd0)
      begin n_fail++; $display("FAIL rst_mid_qr: got q=%h r=%h want 0000 0000", q, r); end
    n_cmp++; if (dz !== 1'b0 || ov !== 1'b0 || ir !== 1'b1)
      begin n_fail++; $display("FAIL rst_mid_flags: got dz=%b ov=%b ir=%b want 0 0 1", dz, ov, ir); end
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(16'd81, 8'd9, 1'b1, qo, ro, dzo, lat);
    n_cmp++; if (qo !== 16'd9 || ro !== 16'd0 || lat != 16)
      begin n_fail++; $display("FAIL after_rst_81_9: got q=%0d r=%0d lat=%0d want 9 0 16", qo, ro, lat); end
  endtask

  task automatic test_back_to_back();
    int k;
    ordy = 1'b1; n = 16'd100; d = 8'd3; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    k = 0;
    while (ir !== 1'b1 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++; if (k != 17) begin n_fail++; $display("FAIL b2b_period: got %0d want 17", k); end
    n_cmp++; if (q !== 16'd33 || r !== 16'd1)
      begin n_fail++; $display("FAIL b2b_result: got q=%0d r=%0d want 33 1", q, r); end
    ordy = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] qo, ro, a, eq, er;
    logic [7:0]  b;
    logic        dzo;
    int          lat;
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      b = 8'($urandom_range(1, 255));
      run_op(a, b, 1'b1, qo, ro, dzo, lat);
      n_cmp++;
      if (qo !== a / 16'(b) || ro !== a % 16'(b) || lat != 16 || dzo !== 1'b0 ||
          32'(qo) * 32'(b) + 32'(ro) != 32'(a)) begin
        n_fail++;
        $display("FAIL rnd_%0d: %0d/%0d got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=16",
                 i, a, b, qo, ro, lat, a / 16'(b), a % 16'(b));
      end
    end
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      b = 8'($urandom_range(1, 255));
      eq = ((a >> 4) / 16'(b)) << 4;
      er = a - 16'(32'(eq) * 32'(b));
      n = a; d = b; iv4 = 1'b1;
      @(posedge clk); #1;
      iv4 = 1'b0;
      lat = 0;
      while (ov4 !== 1'b1 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      n_cmp++;
      if (q4 !== eq || r4 !== er || lat != 12) begin
        n_fail++;
        $display("FAIL rnd4_%0d: %0d/%0d got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=12",
                 i, a, b, q4, r4, lat, eq, er);
      end
      ordy4 = 1'b1;
      @(posedge clk); #1;
      ordy4 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_exact();
    test_div_zero();
    test_skip4();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
